// File: rtl/nfifo_reader.sv
// rtl/nfifo_reader.sv - FWFT FIFO read adapter with 2-entry skid buffer and packet framing
// Pops the FIFO into head/tail slots and presents them as a valid/ready stream with last/count.
module nfifo_reader #(
  parameter int width   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fifo_empty_i,
  input  logic [width-1:0] fifo_data_i,
  output logic             fifo_read_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [width-1:0] data_o,
  output logic             last_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  occ_t             occ;
  logic [width-1:0] head;
  logic [width-1:0] tail;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Pop decision uses only buffer state and the empty flag, never ready_i.
  assign fifo_read_o = ~rst_i & ~fifo_empty_i & (occ != TWO);
  assign push        = fifo_read_o;
  assign valid_o     = (occ != EMPTY);
  assign pop         = valid_o & ready_i;
  assign data_o      = head;
  assign last_o      = valid_o & (idx == LAST_IDX);
  assign count_o     = count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ   <= EMPTY;
      head  <= '0;
      tail  <= '0;
      idx   <= '0;
      count <= '0;
    end else begin
      case (occ)
        EMPTY: begin
          if (push) begin
            head <= fifo_data_i;
            occ  <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail <= fifo_data_i;
              occ  <= TWO;
            end
            2'b01: occ <= EMPTY;
            2'b11: head <= fifo_data_i;
            default: ;
          endcase
        end
        TWO: begin
          if (pop) begin
            head <= tail;
            occ  <= ONE;
          end
        end
        default: occ <= EMPTY;
      endcase

      if (pop) begin
        count <= count + 1'b1;
        idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nfifo_reader.sv
// tb/tb_nfifo_reader.sv - randomized and directed bench for nfifo_reader against a queue model
// Instance a: PKT_LEN=4, CNT_W=4. Instance b: PKT_LEN=1, CNT_W=16 fed by a counting FIFO.
module tb_nfifo_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty_a = 1'b1, fifo_read_a, valid_a, ready_a = 1'b0, last_a;
  logic [7:0]  fifo_data_a = '0, data_a;
  logic [3:0]  count_a;
  logic        fifo_empty_b = 1'b1, fifo_read_b, valid_b, ready_b = 1'b0, last_b;
  logic [7:0]  fifo_data_b = '0, data_b;
  logic [15:0] count_b;

  nfifo_reader #(.width(8), .PKT_LEN(4), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(fifo_empty_a), .fifo_data_i(fifo_data_a),
    .fifo_read_o(fifo_read_a), .valid_o(valid_a), .ready_i(ready_a),
    .data_o(data_a), .last_o(last_a), .count_o(count_a));

  nfifo_reader #(.width(8), .PKT_LEN(1), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .fifo_empty_i(fifo_empty_b), .fifo_data_i(fifo_data_b),
    .fifo_read_o(fifo_read_b), .valid_o(valid_b), .ready_i(ready_b),
    .data_o(data_b), .last_o(last_b), .count_o(count_b));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model state: q is the FIFO content, ex_* the words held by the adapter in order.
  bit         rst_req = 1'b1;
  bit         rdy_a   = 1'b0;
  logic [7:0] q[$];
  logic [7:0] ex_a[$];
  logic [7:0] ex_b[$];
  int         xfer_a = 0, xfer_b = 0, pops_a = 0, cyc = 0;
  int         first_read = -1, first_valid = -1;
  int         xfer_cyc[$];
  logic [7:0] xfer_dat[$];
  logic [7:0] b_head = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else
      passed++;
  endtask

  task automatic clear_models();
    ex_a.delete();
    ex_b.delete();
    xfer_a = 0;
    xfer_b = 0;
  endtask

  task automatic compare();
    check("a_valid", valid_a, ex_a.size() != 0);
    check("a_read", fifo_read_a, !rst && !fifo_empty_a && ex_a.size() < 2);
    check("a_count", count_a, xfer_a % 16);
    if (ex_a.size() != 0) begin
      check("a_data", data_a, ex_a[0]);
      check("a_last", last_a, (xfer_a % 4) == 3);
    end else begin
      check("a_last_idle", last_a, 0);
    end
    check("b_valid", valid_b, ex_b.size() != 0);
    check("b_read", fifo_read_b, !rst && !fifo_empty_b && ex_b.size() < 2);
    check("b_last", last_b, ex_b.size() != 0);
    check("b_count", count_b, xfer_b % 65536);
    if (ex_b.size() != 0) check("b_data", data_b, ex_b[0]);
    if (valid_a && first_valid < 0) first_valid = cyc;
  endtask

  task automatic advance();
    if (valid_a && ready_a) begin
      xfer_cyc.push_back(cyc);
      xfer_dat.push_back(data_a);
      void'(ex_a.pop_front());
      xfer_a++;
    end
    if (fifo_read_a && q.size() > 0) begin
      ex_a.push_back(q.pop_front());
      pops_a++;
      if (first_read < 0) first_read = cyc;
    end
    if (valid_b && ready_b) begin
      void'(ex_b.pop_front());
      xfer_b++;
    end
    if (fifo_read_b) begin
      ex_b.push_back(b_head);
      b_head = b_head + 8'd1;
    end
  endtask

  // Inputs change at negedge, outputs are compared 1ns later, the model predicts the next posedge.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    rst          = rst_req;
    if (rst) clear_models();
    ready_a      = rdy_a;
    fifo_empty_a = (q.size() == 0);
    fifo_data_a  = (q.size() != 0) ? q[0] : 8'($urandom);
    ready_b      = 1'($urandom_range(0, 1));
    fifo_empty_b = ($urandom_range(0, 3) == 0);
    fifo_data_b  = b_head;
    #1;
    compare();
    if (!rst) advance();
  endtask

  task automatic wait_xfer(input int n, input int budget);
    int k;
    k = 0;
    while (xfer_a < n && k < budget) begin
      cycle();
      k++;
    end
    if (xfer_a < n) check("xfer_timeout", xfer_a, n);
  endtask

  task automatic reset_pulse();
    rst_req = 1'b1;
    cycle();
    cycle();
    rst_req = 1'b0;
  endtask

  task automatic clear_logs();
    xfer_cyc.delete();
    xfer_dat.delete();
    pops_a = 0;
    first_read = -1;
    first_valid = -1;
  endtask

  initial begin
    // Reset state
    cycle();
    check("rst_data", data_a, 0);
    check("rst_valid", valid_a, 0);
    cycle();
    rst_req = 1'b0;

    // 1..10 with ready held high
    clear_logs();
    rdy_a = 1'b1;
    for (int i = 1; i <= 10; i++) q.push_back(8'(i));
    wait_xfer(10, 60);
    cycle();
    check("t1_count", count_a, 10);
    check("t1_latency", first_valid - first_read, 1);
    if (xfer_cyc.size() == 10) begin
      check("t1_no_gap", xfer_cyc[9] - xfer_cyc[0], 9);
      for (int i = 0; i < 10; i++) check("t1_word", xfer_dat[i], i + 1);
    end else check("t1_nxfer", xfer_cyc.size(), 10);

    // 1..10 with ready low: only two pops, head held
    clear_logs();
    rdy_a = 1'b0;
    for (int i = 1; i <= 10; i++) q.push_back(8'(i));
    repeat (6) cycle();
    check("t2_pops", pops_a, 2);
    check("t2_read_off", fifo_read_a, 0);
    check("t2_valid", valid_a, 1);
    check("t2_head", data_a, 1);
    rdy_a = 1'b1;
    wait_xfer(20, 60);
    if (xfer_cyc.size() == 10) begin
      check("t2_no_gap", xfer_cyc[9] - xfer_cyc[0], 9);
      for (int i = 0; i < 10; i++) check("t2_word", xfer_dat[i], i + 1);
    end else check("t2_nxfer", xfer_cyc.size(), 10);

    // Empty FIFO with ready high: idle and count steady at 20 mod 16
    repeat (5) cycle();
    check("t4_valid", valid_a, 0);
    check("t4_read", fifo_read_a, 0);
    check("t4_count", count_a, 4);

    // Alternating ready with FIFO kept non-empty
    for (int i = 0; i < 40; i++) begin
      while (q.size() < 3) q.push_back(8'($urandom));
      rdy_a = (i % 2) == 0;
      cycle();
    end

    // Fully random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) q.push_back(8'($urandom));
      rdy_a = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rdy_a = 1'b1;
    repeat (q.size() + 4) cycle();

    // Counter wrap with CNT_W=4: 17 transfers leave count at 1
    reset_pulse();
    rdy_a = 1'b1;
    for (int i = 0; i < 17; i++) q.push_back(8'($urandom));
    wait_xfer(17, 80);
    rdy_a = 1'b0;
    cycle();
    check("t5_wrap", count_a, 1);

    // Async reset mid-stream with two words buffered and packet index 2
    reset_pulse();
    rdy_a = 1'b1;
    for (int i = 0; i < 8; i++) q.push_back(8'(8'h40 + i));
    wait_xfer(2, 20);
    rdy_a = 1'b0;
    for (int k = 0; k < 10 && ex_a.size() < 2; k++) cycle();
    cycle();
    check("t6_pre_valid", valid_a, 1);
    check("t6_pre_count", count_a, 2);
    #2;
    rst = 1'b1;
    rst_req = 1'b1;
    #1;
    check("t6_valid_async", valid_a, 0);
    check("t6_last_async", last_a, 0);
    check("t6_count_async", count_a, 0);
    clear_models();
    cycle();
    rst_req = 1'b0;
    clear_logs();
    rdy_a = 1'b1;
    wait_xfer(4, 30);
    if (xfer_dat.size() >= 1) check("t6_next_word", xfer_dat[0], 8'h44);
    cycle();
    check("t6_count_after", count_a, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nfifo_reader.md
Name: nfifo_reader

Overview:
- Read-side adapter for nfifo_inf. Drains a first-word-fall-through FIFO through its empty/read interface and presents the words as a registered valid/ready stream.
- Each word is tagged with packet framing: last_o marks every PKT_LEN-th word.
- A 2-entry output buffer decouples the FIFO pop from downstream backpressure. There is no combinational path from ready_i to fifo_read_o.
- Sits between nfifo_inf (data_o/empty_o/read_i) and a downstream router or NoC port.

Parameters:
- width, 8, data word width (matches nfifo_inf width).
- PKT_LEN, 4, words per packet, >=1. last_o is asserted on word index PKT_LEN-1.
- CNT_W, 16, width of the transfer counter count_o.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- fifo_empty_i  input  1  FIFO empty flag (connect to nfifo_inf empty_o).
- fifo_data_i  input  width  FIFO head word, valid whenever fifo_empty_i=0 (FWFT).
- fifo_read_o  output  1  pop strobe to FIFO read_i. Pops the head on the clock edge where it is 1.
- valid_o  output  1  data_o/last_o hold a valid word.
- ready_i  input  1  downstream accepts the word; transfer = valid_o & ready_i.
- data_o  output  width  buffer head word.
- last_o  output  1  head word is the final word of a packet.
- count_o  output  CNT_W  total transfers since reset, modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): buffer occupancy=0, valid_o=0, data_o=0, last_o=0, count_o=0, packet index=0, fifo_read_o=0.
- Occupancy states: EMPTY(0), ONE(1), TWO(2). Storage is 2 registered slots (head, tail).
- fifo_read_o = ~fifo_empty_i & (occ != TWO). This is purely a function of registered state and fifo_empty_i. It never asserts while empty.
- Push = fifo_read_o. Pop = valid_o & ready_i.
- Occupancy transitions:
  - EMPTY: on push -> ONE; the head loads fifo_data_i.
  - ONE: push only -> TWO (tail loads); pop only -> EMPTY; push & pop -> ONE (head loads fifo_data_i).
  - TWO: pop -> ONE (tail moves to head); no push possible.
- Latency: a word popped at edge N is on data_o with valid_o=1 after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle sustained with ready_i held high.
- valid_o = (occ != EMPTY). data_o and last_o are stable while valid_o=1 and ready_i=0. data_o keeps its last value when the buffer empties.
- Packet index (0..PKT_LEN-1) increments on each transfer and wraps to 0 after PKT_LEN-1.
  - last_o = valid_o & (index == PKT_LEN-1).
  - With PKT_LEN=1, last_o = valid_o.
- count_o increments by 1 per transfer and wraps from 2^CNT_W-1 to 0.
- Word order is strictly preserved; no drop, no duplication.
- Reset mid-operation clears buffered words and the packet index immediately. FIFO contents are untouched.

Test Plan:
- Reset then 10 writes of 1..10 into nfifo_inf, ready_i=1 -> data_o sequence 1..10 on consecutive cycles, first valid one cycle after first pop; last_o on words 4 and 8; count_o=10.
- Same stimulus, ready_i=0 -> exactly 2 pops, then fifo_read_o=0; valid_o=1 with data_o=1 held. Raise ready_i -> 1..10 delivered in order with no gaps.
- ready_i toggling 1,0,1,0... with the FIFO continuously non-empty -> no lost or duplicated words; occupancy never exceeds 2; fifo_read_o is never 1 while fifo_empty_i=1.
- Empty FIFO, ready_i=1 -> valid_o=0, fifo_read_o=0, count_o unchanged.
- CNT_W=4, 17 transfers -> count_o wraps to 1. PKT_LEN=1 -> last_o=1 on every word.
- Assert rst_i mid-stream with occ=2 and index=2 -> valid_o, last_o, count_o clear at once without waiting for a clock edge. The next delivered word is index 0.
